// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the AES key schedule slice:
//   - key_len encodings and the FSM state type
//   - keyCfg():    key_len -> {Nk, Nr} lookup (zeros for the illegal code)
//   - xtime():     GF(2^8) multiply-by-2, used to step the round constant
//   - sboxLookup(): forward AES S-box
//   - RCON_INIT:   first round constant
// ---------------------------------------------------------------------------
package aes_pkg;

  localparam logic [1:0] KEYLEN_128 = 2'b00;
  localparam logic [1:0] KEYLEN_192 = 2'b01;
  localparam logic [1:0] KEYLEN_256 = 2'b10;
  localparam logic [1:0] KEYLEN_BAD = 2'b11;

  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef enum logic {
    ST_IDLE,
    ST_EXPAND
  } state_e;

  typedef struct packed {
    logic [3:0] nk;
    logic [3:0] nr;
  } keyCfg_t;

  // Element 0 sits in the most significant byte of the first row literal.
  localparam logic [0:255][7:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Illegal code returns Nk=0 so callers can reject it without a second table.
  function automatic keyCfg_t keyCfg(input logic [1:0] kl);
    keyCfg_t c;
    case (kl)
      KEYLEN_128: c = '{nk: 4'd4, nr: 4'd10};
      KEYLEN_192: c = '{nk: 4'd6, nr: 4'd12};
      KEYLEN_256: c = '{nk: 4'd8, nr: 4'd14};
      default:    c = '{nk: 4'd0, nr: 4'd0};
    endcase
    return c;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] sboxLookup(input logic [7:0] a);
    return SBOX_TABLE[a];
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// ---------------------------------------------------------------------------
// aes_sbox
// Single-byte forward AES S-box; four of these form the shared SubWord unit.
// Ports:
//   a_i  in  8  input byte
//   y_o  out 8  substituted byte
// ---------------------------------------------------------------------------
module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  import aes_pkg::*;

  assign y_o = sboxLookup(a_i);

endmodule

// File: rtl/aes_key_expander.sv
// ---------------------------------------------------------------------------
// aes_key_expander
// Sequential AES-128/192/256 key schedule generator. One 32-bit schedule word
// is produced per clock through a single shared SubWord unit and written to
// an internal round-key store, which the cipher reads combinationally (or
// through one register stage when RD_LATCH=1).
//
// Parameters:
//   MAX_NK    largest key length in words (4, 6 or 8); store is 4*(MAX_NK+7)
//   RD_LATCH  1 = registered read data, 0 = combinational read data
//
// Ports:
//   clk          in   1    clock
//   rst_n        in   1    asynchronous active-low reset
//   start        in   1    expansion request
//   key_len      in   2    00=128, 01=192, 10=256, 11=illegal
//   key          in   256  cipher key, MSB-aligned
//   busy         out  1    expansion in progress
//   ready        out  1    schedule valid for last accepted key
//   err          out  1    one-cycle pulse on an illegal request
//   nr           out  4    round count of the loaded schedule
//   rk_rd_round  in   4    round index to read
//   rk_rd_data   out  128  {w[4r], w[4r+1], w[4r+2], w[4r+3]}
//
// Build option:
//   AES_KEYEXP_RDLOCK_EN  when defined, rk_rd_data reads as zero while
//                         ready=0 so a partial or stale schedule is hidden.
// ---------------------------------------------------------------------------
module aes_key_expander #(
  parameter int MAX_NK   = 8,
  parameter int RD_LATCH = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [255:0] key,
  output logic         busy,
  output logic         ready,
  output logic         err,
  output logic [3:0]   nr,
  input  logic [3:0]   rk_rd_round,
  output logic [127:0] rk_rd_data
);
  import aes_pkg::*;

  localparam int DEPTH = 4 * (MAX_NK + 7);
  localparam int AW    = $clog2(DEPTH);

  state_e        state_q;
  logic          busy_q;
  logic          ready_q;
  logic          err_q;
  logic [3:0]    nr_q;
  logic [3:0]    nrPend_q;
  logic [3:0]    nk_q;
  logic [AW-1:0] wordIdx_q;
  logic [2:0]    nkPos_q;
  logic [7:0]    rcon_q;
  logic [31:0]   store_q [DEPTH];

  // Request decode: a request is legal only if its key fits the store.
  keyCfg_t reqCfg;
  logic    reqLegal;
  logic    acceptReq;

  assign reqCfg    = keyCfg(key_len);
  assign reqLegal  = (key_len != KEYLEN_BAD) && (int'(reqCfg.nk) <= MAX_NK);
  assign acceptReq = (state_q == ST_IDLE) && start && reqLegal;

  // Key split into 32-bit words, word 0 taken from the top of the bus.
  logic [31:0] keyWord [8];
  for (genvar g = 0; g < 8; g++) begin : g_keyword
    assign keyWord[g] = key[255-32*g -: 32];
  end

  // Schedule word datapath. Addresses are parked at zero in IDLE so the
  // store is never indexed below word 0.
  logic [AW-1:0] prevAddr;
  logic [AW-1:0] backAddr;
  logic [AW-1:0] lastIdx;
  logic [31:0]   prevWord;
  logic [31:0]   backWord;
  logic [31:0]   sboxIn;
  logic [31:0]   subOut;
  logic [31:0]   tempWord;
  logic [31:0]   newWord_d;
  logic          posWrap;

  assign prevAddr = (state_q == ST_EXPAND) ? wordIdx_q - AW'(1)    : '0;
  assign backAddr = (state_q == ST_EXPAND) ? wordIdx_q - AW'(nk_q) : '0;
  assign prevWord = store_q[prevAddr];
  assign backWord = store_q[backAddr];

  // Final word index is 4*(Nr+1)-1 = {Nr, 2'b11}.
  assign lastIdx  = AW'({nrPend_q, 2'b11});
  assign posWrap  = ({1'b0, nkPos_q} == (nk_q - 4'd1));

  // RotWord is only applied at the start of each Nk-word group.
  assign sboxIn = (nkPos_q == 3'd0) ? {prevWord[23:0], prevWord[31:24]} : prevWord;

  for (genvar b = 0; b < 4; b++) begin : g_subword
    aes_sbox u_sbox (
      .a_i(sboxIn[8*b +: 8]),
      .y_o(subOut[8*b +: 8])
    );
  end

  // Select the transformed temp word: Rcon step at group start, extra
  // SubWord halfway through a 256-bit group, plain copy otherwise.
  always_comb begin
    tempWord = prevWord;
    if (nkPos_q == 3'd0) begin
      tempWord = subOut ^ {rcon_q, 24'h000000};
    end else if ((nk_q == 4'd8) && (nkPos_q == 3'd4)) begin
      tempWord = subOut;
    end
  end

  assign newWord_d = backWord ^ tempWord;

  // Control FSM: loads the key configuration on accept, then walks the
  // schedule one word per clock and flags completion on the last word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      nr_q      <= '0;
      nrPend_q  <= '0;
      nk_q      <= '0;
      wordIdx_q <= '0;
      nkPos_q   <= '0;
      rcon_q    <= RCON_INIT;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (reqLegal) begin
              nk_q      <= reqCfg.nk;
              nrPend_q  <= reqCfg.nr;
              wordIdx_q <= AW'(reqCfg.nk);
              nkPos_q   <= '0;
              rcon_q    <= RCON_INIT;
              busy_q    <= 1'b1;
              ready_q   <= 1'b0;
              state_q   <= ST_EXPAND;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_EXPAND: begin
          if (nkPos_q == 3'd0) begin
            rcon_q <= xtime(rcon_q);
          end
          nkPos_q   <= posWrap ? 3'd0 : nkPos_q + 3'd1;
          wordIdx_q <= wordIdx_q + AW'(1);
          if (wordIdx_q == lastIdx) begin
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            nr_q    <= nrPend_q;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Round-key store: key words land on the accept edge, then one expanded
  // word per EXPAND cycle at the current word index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < DEPTH; j++) begin
        store_q[AW'(j)] <= '0;
      end
    end else if (acceptReq) begin
      for (int j = 0; j < 8; j++) begin
        if (j < int'(reqCfg.nk)) begin
          store_q[AW'(j)] <= keyWord[3'(j)];
        end
      end
    end else if (state_q == ST_EXPAND) begin
      store_q[wordIdx_q] <= newWord_d;
    end
  end

  // Read port: rounds beyond the loaded schedule read as zero, which also
  // keeps the store index in range.
  logic [AW-1:0] rdBase;
  logic [127:0]  rdWord;

  assign rdBase = AW'({rk_rd_round, 2'b00});

  always_comb begin
    rdWord = '0;
    if (rk_rd_round <= nr_q) begin
      rdWord = {store_q[rdBase],
                store_q[rdBase + AW'(1)],
                store_q[rdBase + AW'(2)],
                store_q[rdBase + AW'(3)]};
    end
`ifdef AES_KEYEXP_RDLOCK_EN
    if (!ready_q) begin
      rdWord = '0;
    end
`endif
  end

  // Optional output register on the read path.
  if (RD_LATCH != 0) begin : g_rd_reg
    logic [127:0] rdData_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdData_q <= '0;
      end else begin
        rdData_q <= rdWord;
      end
    end
    assign rk_rd_data = rdData_q;
  end else begin : g_rd_comb
    assign rk_rd_data = rdWord;
  end

  assign busy  = busy_q;
  assign ready = ready_q;
  assign err   = err_q;
  assign nr    = nr_q;

endmodule

// File: tb/tb_aes_key_expander.sv
// ---------------------------------------------------------------------------
// tb_aes_key_expander
// Directed checks of the sequential AES key schedule against FIPS-197
// reference schedules for all three key lengths, plus busy-start, mid-run
// reset and illegal key_len handling.
// ---------------------------------------------------------------------------
module tb_aes_key_expander;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   key_len;
  logic [255:0] key;
  logic         busy;
  logic         ready;
  logic         err;
  logic [3:0]   nr;
  logic [3:0]   rk_rd_round;
  logic [127:0] rk_rd_data;

  int vecCount  = 0;
  int missCount = 0;

  aes_key_expander #(
    .MAX_NK  (8),
    .RD_LATCH(0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .key_len    (key_len),
    .key        (key),
    .busy       (busy),
    .ready      (ready),
    .err        (err),
    .nr         (nr),
    .rk_rd_round(rk_rd_round),
    .rk_rd_data (rk_rd_data)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  // Present a request for exactly one rising edge; returns 1 time unit
  // after that edge.
  task automatic applyStimulus(input logic [1:0] kl, input logic [255:0] k);
    @(negedge clk);
    start   = 1'b1;
    key_len = kl;
    key     = k;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count edges until ready rises (bounded). Optionally raises start for one
  // edge after cycle injectAt with a different key, and records any err.
  task automatic waitReady(input int injectAt, input logic [255:0] injKey,
                           output int cycles, output logic errSeen);
    cycles  = 0;
    errSeen = 1'b0;
    while (!ready && cycles < 100) begin
      @(posedge clk);
      #1;
      cycles++;
      errSeen = errSeen | err;
      start   = (cycles == injectAt);
      if (cycles == injectAt) begin
        key     = injKey;
        key_len = 2'b10;
      end
    end
    start = 1'b0;
  endtask

  task automatic readRound(input logic [3:0] r, output logic [127:0] d);
    rk_rd_round = r;
    #1;
    d = rk_rd_data;
  endtask

  initial begin
    logic [127:0] rd;
    int           cyc;
    logic         errSeen;

    rst_n       = 1'b0;
    start       = 1'b0;
    key_len     = 2'b00;
    key         = '0;
    rk_rd_round = 4'd0;

    #12;
    checkOutput("reset_busy",  128'(busy),  128'd0);
    checkOutput("reset_ready", 128'(ready), 128'd0);
    checkOutput("reset_err",   128'(err),   128'd0);
    checkOutput("reset_nr",    128'(nr),    128'd0);
    checkOutput("reset_rd",    rk_rd_data,  128'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // AES-128
    applyStimulus(2'b00, K128);
    checkOutput("k128_busy_after_accept", 128'(busy), 128'd1);
    readRound(4'd0, rd);
`ifdef AES_KEYEXP_RDLOCK_EN
    checkOutput("k128_rd_while_busy", rd, 128'd0);
`else
    checkOutput("k128_rd_while_busy", rd, 128'h2b7e151628aed2a6abf7158809cf4f3c);
`endif
    waitReady(-1, '0, cyc, errSeen);
    checkOutput("k128_latency", 128'(cyc), 128'd40);
    checkOutput("k128_busy_done", 128'(busy), 128'd0);
    checkOutput("k128_nr", 128'(nr), 128'd10);
    readRound(4'd0, rd);
    checkOutput("k128_round0", rd, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    readRound(4'd1, rd);
    checkOutput("k128_round1", rd, 128'ha0fafe1788542cb123a339392a6c7605);
    readRound(4'd10, rd);
    checkOutput("k128_round10", rd, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    readRound(4'd11, rd);
    checkOutput("k128_round11_zero", rd, 128'd0);

    // Illegal key length: one-cycle err, nothing else moves
    applyStimulus(2'b11, K256);
    checkOutput("bad_err_pulse", 128'(err),   128'd1);
    checkOutput("bad_busy",      128'(busy),  128'd0);
    checkOutput("bad_ready",     128'(ready), 128'd1);
    @(posedge clk);
    #1;
    checkOutput("bad_err_clear", 128'(err), 128'd0);

    // AES-192, issued while the previous schedule is ready
    applyStimulus(2'b01, K192);
    checkOutput("k192_ready_drop", 128'(ready), 128'd0);
    waitReady(-1, '0, cyc, errSeen);
    checkOutput("k192_latency", 128'(cyc), 128'd46);
    checkOutput("k192_nr", 128'(nr), 128'd12);
    readRound(4'd1, rd);
    checkOutput("k192_round1", rd, 128'h62f8ead2522c6b7bfe0c91f72402f5a5);
    readRound(4'd12, rd);
    checkOutput("k192_w51", rd[31:0], 128'h01002202);

    // AES-256
    applyStimulus(2'b10, K256);
    waitReady(-1, '0, cyc, errSeen);
    checkOutput("k256_latency", 128'(cyc), 128'd52);
    checkOutput("k256_nr", 128'(nr), 128'd14);
    readRound(4'd2, rd);
    checkOutput("k256_w8_rcon", rd[127:96], 128'h9ba35411);
    readRound(4'd3, rd);
    checkOutput("k256_w12_subword", rd[127:96], 128'ha8b09c1a);
    readRound(4'd14, rd);
    checkOutput("k256_w59", rd[31:0], 128'h706c631e);
    readRound(4'd15, rd);
    checkOutput("k256_round15_zero", rd, 128'd0);

    // start while busy must be ignored
    applyStimulus(2'b00, K128);
    waitReady(10, K256, cyc, errSeen);
    checkOutput("busy_start_latency", 128'(cyc), 128'd40);
    checkOutput("busy_start_no_err", 128'(errSeen), 128'd0);
    checkOutput("busy_start_nr", 128'(nr), 128'd10);
    readRound(4'd10, rd);
    checkOutput("busy_start_round10", rd, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Reset in the middle of an expansion
    applyStimulus(2'b00, K128);
    repeat (20) @(posedge clk);
    #1;
    rk_rd_round = 4'd0;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy",  128'(busy),  128'd0);
    checkOutput("midrst_ready", 128'(ready), 128'd0);
    checkOutput("midrst_nr",    128'(nr),    128'd0);
    checkOutput("midrst_rd",    rk_rd_data,  128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(2'b00, K128);
    waitReady(-1, '0, cyc, errSeen);
    checkOutput("postrst_latency", 128'(cyc), 128'd40);
    readRound(4'd10, rd);
    checkOutput("postrst_round10", rd, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
